// File: rtl/run_sequencer_if.sv
// Bundle between the run sequencer and the host/core side.
// The host drives start and returns the core's done flag; the sequencer drives everything else.
interface run_sequencer_if #(
    parameter int CW = 16
);
    logic          start;
    logic          core_done;
    logic          core_reset;
    logic          core_req;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;

    modport master (
        output start,
        output core_done,
        input  core_reset,
        input  core_req,
        input  busy,
        input  done,
        input  timeout,
        input  cycle_count
    );

    modport slave (
        input  start,
        input  core_done,
        output core_reset,
        output core_req,
        output busy,
        output done,
        output timeout,
        output cycle_count
    );
endinterface

// File: rtl/run_sequencer.sv
// Run controller for the single-cycle core: holds it in reset, pulses req,
// then counts execution cycles until done or the watchdog fires.
module run_sequencer #(
    parameter int RST_CYC = 2,
    parameter int CW      = 16,
    parameter int MAX_CYC = 4000
) (
    input  logic           clk,
    input  logic           reset,
    run_sequencer_if.slave bus
);
    localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYC - 1);
    localparam logic [CW-1:0] LAST_CYC = CW'(MAX_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        RST,
        RUN,
        DONE
    } state_t;

    state_t        state_reg;
    logic [RW-1:0] rst_cnt_reg;
    logic [CW-1:0] count_reg;
    logic          timeout_reg;
    logic          req_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            rst_cnt_reg <= '0;
            count_reg   <= '0;
            timeout_reg <= 1'b0;
            req_reg     <= 1'b0;
        end else begin
            req_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_reg   <= RST;
                        rst_cnt_reg <= RST_LOAD;
                        count_reg   <= '0;
                        timeout_reg <= 1'b0;
                    end
                end
                RST: begin
                    if (rst_cnt_reg == '0) begin
                        state_reg <= RUN;
                        req_reg   <= 1'b1;
                    end else begin
                        rst_cnt_reg <= rst_cnt_reg - 1'b1;
                    end
                end
                RUN: begin
                    // The sampling cycle is counted; completion beats the watchdog on a tie.
                    count_reg <= count_reg + 1'b1;
                    if (bus.core_done) begin
                        state_reg   <= DONE;
                        timeout_reg <= 1'b0;
                    end else if (count_reg == LAST_CYC) begin
                        state_reg   <= DONE;
                        timeout_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.core_reset  = (state_reg == IDLE) || (state_reg == RST);
    assign bus.busy        = (state_reg == RST) || (state_reg == RUN);
    assign bus.done        = (state_reg == DONE);
    assign bus.core_req    = req_reg;
    assign bus.timeout     = timeout_reg;
    assign bus.cycle_count = count_reg;
endmodule
